// File: rtl/cavlc_residual_scanner_pkg.sv
// Shared types for the CAVLC residual scanner (encoder side).
// Holds the FSM state encodings, max_coeff codes and the pair bundle.
package cavlc_residual_scanner_pkg;

    localparam int COEFF_W = 16;
    localparam int NCOEFF  = 16;

    typedef enum logic [2:0] {
        CAVLC_ENC_IDLE,
        CAVLC_ENC_LOAD,
        CAVLC_ENC_SUMMARY,
        CAVLC_ENC_EMIT,
        CAVLC_ENC_DONE
    } enc_state_e;

    localparam logic [4:0] MAXC_LUMA = 5'd16;
    localparam logic [4:0] MAXC_AC   = 5'd15;
    localparam logic [4:0] MAXC_CDC  = 5'd4;

    typedef struct packed {
        logic [COEFF_W-1:0] level;
        logic [3:0]         run;
        logic               last;
    } pair_t;

    // Unknown block sizes fall back to a full 4x4 block.
    function automatic logic [4:0] decode_max(input logic [4:0] m);
        if (m == MAXC_AC || m == MAXC_CDC) begin
            return m;
        end
        return MAXC_LUMA;
    endfunction

endpackage

// File: rtl/cavlc_coeff_buffer.sv
// 16x16-bit coefficient register file, one write port, one async read.
// Ports: clk/reset_n, we/waddr/wdata write side, raddr -> rdata read side.
module cavlc_coeff_buffer
    import cavlc_residual_scanner_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               we,
    input  logic [3:0]         waddr,
    input  logic [COEFF_W-1:0] wdata,
    input  logic [3:0]         raddr,
    output logic [COEFF_W-1:0] rdata
);

    logic [COEFF_W-1:0] mem_q [NCOEFF];
    logic [COEFF_W-1:0] mem_d [NCOEFF];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/cavlc_residual_scanner.sv
// CAVLC residual scanner: loads one zig-zag block, reports the summary,
// then emits (level, run_before) pairs from highest index downward.
// Ports: start/max_coeff, coeff_valid/coeff_in in; sum_* and pair_*
// valid/ready outputs; busy and end_of_one_residual_block status.
module cavlc_residual_scanner
    import cavlc_residual_scanner_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [4:0]                max_coeff,
    input  logic                      coeff_valid,
    input  logic signed [COEFF_W-1:0] coeff_in,
    output logic                      busy,
    output logic                      sum_valid,
    input  logic                      sum_ready,
    output logic [4:0]                TotalCoeff,
    output logic [1:0]                TrailingOnes,
    output logic [3:0]                TotalZeros,
    output logic                      pair_valid,
    input  logic                      pair_ready,
    output logic signed [COEFF_W-1:0] level,
    output logic [3:0]                run_before,
    output logic                      last_pair,
    output logic [4:0]                i_TotalCoeff,
    output logic                      end_of_one_residual_block
);

    enc_state_e state_q, state_d;
    logic [4:0] maxc_q, maxc_d;
    logic [4:0] idx_q, idx_d;
    logic [4:0] tc_q, tc_d;
    logic [1:0] t1_q, t1_d;
    logic [3:0] last_nz_q, last_nz_d;
    logic [3:0] tz_q, tz_d;
    logic       sum_valid_q, sum_valid_d;
    logic       busy_q, busy_d;
    logic       eob_q, eob_d;
    // ptr[4] set means the walk has passed index 0.
    logic [4:0] ptr_q, ptr_d;
    logic       pend_q, pend_d;
    logic [COEFF_W-1:0] lvl_q, lvl_d;
    logic [3:0] zcnt_q, zcnt_d;
    logic [4:0] np_q, np_d;
    logic [4:0] itc_q, itc_d;
    pair_t      pair_q, pair_d;
    logic       pair_valid_q, pair_valid_d;

    logic               buf_we;
    logic [COEFF_W-1:0] buf_rdata;
    logic [4:0]         tz_w;
    logic               is_one;
    logic               is_nz;
    logic               can_step;

    cavlc_coeff_buffer u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (buf_we),
        .waddr   (idx_q[3:0]),
        .wdata   (coeff_in),
        .raddr   (ptr_q[3:0]),
        .rdata   (buf_rdata)
    );

    assign is_nz  = coeff_in != '0;
    assign is_one = coeff_in == 16'h0001 || coeff_in == 16'hFFFF;
    // The walk may advance only when the output slot is free or draining.
    assign can_step = !pair_valid_q || pair_ready;

    always_comb begin
        state_d      = state_q;
        maxc_d       = maxc_q;
        idx_d        = idx_q;
        tc_d         = tc_q;
        t1_d         = t1_q;
        last_nz_d    = last_nz_q;
        tz_d         = tz_q;
        sum_valid_d  = sum_valid_q;
        busy_d       = busy_q;
        eob_d        = 1'b0;
        ptr_d        = ptr_q;
        pend_d       = pend_q;
        lvl_d        = lvl_q;
        zcnt_d       = zcnt_q;
        np_d         = np_q;
        itc_d        = itc_q;
        pair_d       = pair_q;
        pair_valid_d = pair_valid_q;
        buf_we       = 1'b0;
        tz_w         = '0;
        unique case (state_q)
            CAVLC_ENC_IDLE: begin
                if (start) begin
                    maxc_d    = decode_max(max_coeff);
                    idx_d     = '0;
                    tc_d      = '0;
                    t1_d      = '0;
                    last_nz_d = '0;
                    tz_d      = '0;
                    busy_d    = 1'b1;
                    state_d   = CAVLC_ENC_LOAD;
                end
            end
            CAVLC_ENC_LOAD: begin
                if (coeff_valid) begin
                    buf_we = 1'b1;
                    idx_d  = idx_q + 5'd1;
                    if (is_nz) begin
                        tc_d      = tc_q + 5'd1;
                        last_nz_d = idx_q[3:0];
                    end
                    if (is_one) begin
                        t1_d = (t1_q == 2'd3) ? 2'd3 : t1_q + 2'd1;
                    end else if (is_nz) begin
                        t1_d = '0;
                    end
                    if (idx_q == maxc_q - 5'd1) begin
                        tz_w        = {1'b0, last_nz_d} + 5'd1 - tc_d;
                        tz_d        = (tc_d == '0) ? 4'd0 : tz_w[3:0];
                        sum_valid_d = 1'b1;
                        state_d     = CAVLC_ENC_SUMMARY;
                    end
                end
            end
            CAVLC_ENC_SUMMARY: begin
                if (sum_ready) begin
                    sum_valid_d = 1'b0;
                    if (tc_q == '0) begin
                        eob_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = CAVLC_ENC_DONE;
                    end else begin
                        ptr_d   = {1'b0, last_nz_q};
                        pend_d  = 1'b0;
                        np_d    = tc_q;
                        itc_d   = tc_q;
                        state_d = CAVLC_ENC_EMIT;
                    end
                end
            end
            CAVLC_ENC_EMIT: begin
                if (pair_valid_q && pair_ready) begin
                    pair_valid_d = 1'b0;
                    itc_d        = itc_q - 5'd1;
                    if (itc_q == 5'd1) begin
                        eob_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = CAVLC_ENC_DONE;
                    end
                end
                if (can_step && np_q != '0) begin
                    if (!pend_q) begin
                        lvl_d  = buf_rdata;
                        pend_d = 1'b1;
                        zcnt_d = '0;
                        ptr_d  = ptr_q - 5'd1;
                    end else if (ptr_q[4] || buf_rdata != '0) begin
                        pair_d       = '{level: lvl_q, run: zcnt_q,
                                         last: np_q == 5'd1};
                        pair_valid_d = 1'b1;
                        np_d         = np_q - 5'd1;
                        // A nonzero that ends one run starts the next pair.
                        if (!ptr_q[4]) begin
                            lvl_d  = buf_rdata;
                            zcnt_d = '0;
                            ptr_d  = ptr_q - 5'd1;
                        end else begin
                            pend_d = 1'b0;
                        end
                    end else begin
                        zcnt_d = zcnt_q + 4'd1;
                        ptr_d  = ptr_q - 5'd1;
                    end
                end
            end
            CAVLC_ENC_DONE: begin
                state_d = CAVLC_ENC_IDLE;
            end
            default: begin
                state_d = CAVLC_ENC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= CAVLC_ENC_IDLE;
            maxc_q       <= MAXC_LUMA;
            idx_q        <= '0;
            tc_q         <= '0;
            t1_q         <= '0;
            last_nz_q    <= '0;
            tz_q         <= '0;
            sum_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            eob_q        <= 1'b0;
            ptr_q        <= '0;
            pend_q       <= 1'b0;
            lvl_q        <= '0;
            zcnt_q       <= '0;
            np_q         <= '0;
            itc_q        <= '0;
            pair_q       <= '0;
            pair_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            maxc_q       <= maxc_d;
            idx_q        <= idx_d;
            tc_q         <= tc_d;
            t1_q         <= t1_d;
            last_nz_q    <= last_nz_d;
            tz_q         <= tz_d;
            sum_valid_q  <= sum_valid_d;
            busy_q       <= busy_d;
            eob_q        <= eob_d;
            ptr_q        <= ptr_d;
            pend_q       <= pend_d;
            lvl_q        <= lvl_d;
            zcnt_q       <= zcnt_d;
            np_q         <= np_d;
            itc_q        <= itc_d;
            pair_q       <= pair_d;
            pair_valid_q <= pair_valid_d;
        end
    end

    assign busy                      = busy_q;
    assign sum_valid                 = sum_valid_q;
    assign TotalCoeff                = tc_q;
    assign TrailingOnes              = t1_q;
    assign TotalZeros                = tz_q;
    assign pair_valid                = pair_valid_q;
    assign level                     = pair_q.level;
    assign run_before                = pair_q.run;
    assign last_pair                 = pair_q.last;
    assign i_TotalCoeff              = itc_q;
    assign end_of_one_residual_block = eob_q;

endmodule

// File: doc/cavlc_residual_scanner.md
# cavlc_residual_scanner

Encoder-side front end of CAVLC residual coding. Takes one residual block's zig-zag-ordered coefficients and produces CAVLC syntax values: a summary (TotalCoeff, TrailingOnes, TotalZeros), then one (level, run_before) pair per nonzero coefficient in reverse scan order. It flags end-of-block the same way the CAVLC decoder side does. It sits between the quantiser/zig-zag stage and the CAVLC VLC table/bit-packer.

## Interface
Parameters:
- none (coefficient width fixed at 16 bits signed; max 16 coefficients)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a block; honoured only in IDLE
- max_coeff  in  5  sampled with start: 16 (luma 4x4), 15 (AC), 4 (chroma DC); any other value is treated as 16
- coeff_valid  in  1  coefficient beat present
- coeff_in  in  16  signed coefficient, scan index 0 first
- busy  out  1  high from accepted start until end of block
- sum_valid  out  1  summary fields valid
- sum_ready  in  1  consumer accepts summary
- TotalCoeff  out  5  nonzero count, 0..16
- TrailingOnes  out  2  0..3
- TotalZeros  out  4  zeros before the last nonzero, 0..15
- pair_valid  out  1  level/run pair valid
- pair_ready  in  1  consumer accepts pair
- level  out  16  signed coefficient value
- run_before  out  4  zeros immediately below this coefficient in scan order
- last_pair  out  1  pair is the lowest-index nonzero
- i_TotalCoeff  out  5  pairs remaining, including the current one
- end_of_one_residual_block  out  1  one-cycle pulse when the block is finished

## Operation
- States: IDLE, LOAD, SUMMARY, EMIT, DONE.
- IDLE: start=1 latches max_coeff, clears counters, sets busy, and moves to LOAD.
- LOAD: each coeff_valid beat writes buf[idx] and increments idx. A nonzero coefficient increments TotalCoeff and sets last_nz=idx.
- LOAD trailing-ones tracking: if |c|==1, t1 = min(t1+1, 3); if |c|>1, t1 = 0; zeros leave t1 unchanged.
- LOAD exit: after beat max_coeff-1, move to SUMMARY. coeff_valid outside LOAD is ignored.
- SUMMARY: TotalZeros = last_nz+1-TotalCoeff, or 0 if TotalCoeff==0. The sum_valid/sum_ready handshake completes the summary.
  - If TotalCoeff==0: go to DONE.
  - Otherwise: go to EMIT with ptr=last_nz and i_TotalCoeff=TotalCoeff.
- EMIT: ptr latches buf[ptr] as the pending level, then walks downward one index per cycle, counting zeros. When it reaches the next nonzero, or passes index 0, it presents the pair.
  - last_pair=1 when i_TotalCoeff==1; its run_before equals the zeros remaining below it.
  - The walk stalls while pair_valid && !pair_ready.
  - On handshake, i_TotalCoeff decrements. When it reaches 0, go to DONE.
- DONE: pulse end_of_one_residual_block for 1 cycle, clear busy, return to IDLE.
- Width rules: run_before saturates naturally (≤15). TotalCoeff ≤ max_coeff.

## Timing
- Reset values: every output is 0, and state is IDLE.
- Reset asserted mid-block aborts immediately. No end pulse is generated, and buffer contents are don't-care.
- sum_valid rises the cycle after the final LOAD beat. Summary fields are registered and stable while sum_valid=1.
- pair_valid/level/run_before/last_pair are registered. They hold stable until pair_ready; valid drops the cycle after acceptance unless the next pair is already resolved.
- Walk cost is one cycle per scanned index. Consumer ready is never combinationally required to produce valid.
- end_of_one_residual_block is asserted in the cycle after the final handshake (summary handshake when TotalCoeff==0, otherwise last pair handshake). busy falls the same cycle.
- start during busy is ignored, and start in the same cycle as the end pulse is ignored. The earliest new start is the cycle after the end pulse; the first coefficient beat is accepted the cycle after start.

## Structure
- Shared define header: state encodings (`CAVLC_ENC_IDLE..DONE`) and max_coeff codes (16/15/4), placed alongside the existing CAVLC decoder state defines.
- Sub-module: cavlc_coeff_buffer, a 16x16-bit register file with 1 write port and 1 asynchronous read port.
- Top level holds the FSM, counters and output registers.

## Test plan
- All-zero 16-coeff block:
  - summary must be TotalCoeff=0, TrailingOnes=0, TotalZeros=0;
  - no pairs;
  - end pulse one cycle after sum handshake.
- Block {0,3,-1,0,0,-1,1,0...0}, max 16 -> TC=4, T1=3, TZ=3; pairs in order:
  - (1,0)
  - (-1,2)
  - (-1,0)
  - (3,1) with last_pair=1.
- All 16 coefficients = 1 -> TC=16, T1=3, TZ=0; 16 pairs, all run 0; i_TotalCoeff counts 16..1.
- Chroma DC, max 4, {0,0,0,-7} -> TC=1, T1=0, TZ=3; single pair (-7,3) with last_pair=1.
- Backpressure: hold pair_ready low for 5 cycles on the 2nd pair -> outputs stable, nothing dropped or duplicated.
- Reset mid-EMIT, then a new block -> all outputs 0 during reset; next block is correct and produces no stale end pulse.
